gb_timer_ng: RTL and testbench

Cycle-accurate, parametrised successor to the DMG/CGB timer/divider. It derives DIV and the TIMA increment from one free-running system counter using falling-edge detection on a selectable tap. It models the delayed TIMA overflow, reload and IRQ sequence, plus the increment glitches caused by DIV/TAC writes. It sits on the CPU I/O bus at FF04–FF07, drives the timer interrupt request, and also gives the APU its frame-sequencer tick.

---
 rtl/gb_timer_pkg.sv | 31 +++
 rtl/gb_timer_ng_fall_edge.sv | 36 +++
 rtl/gb_timer_ng.sv | 187 ++++++++++++++++++
 tb/tb_gb_timer_ng.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gb_timer_pkg
// Description : Shared constants for the gb_timer_ng timer/divider block:
//               CPU register offsets within FF04-FF07, FSM state encoding
//               and the default counter taps.
// Revision    : 1.0 - initial release
// ============================================================================
package gb_timer_pkg;

  // Register offsets on cpu_addr
  localparam logic [1:0] A_DIV  = 2'd0;
  localparam logic [1:0] A_TIMA = 2'd1;
  localparam logic [1:0] A_TMA  = 2'd2;
  localparam logic [1:0] A_TAC  = 2'd3;

  // Overflow sequencer states
  typedef logic [1:0] state_t;
  localparam state_t RUN = 2'd0;  // normal counting
  localparam state_t OVF = 2'd1;  // TIMA reads 00, reload pending
  localparam state_t RLD = 2'd2;  // post-reload window

  // Default taps (bit of the system counter) for a 4 MHz ce
  localparam int DEF_TAP0    = 9;   // 4096 Hz
  localparam int DEF_TAP1    = 3;   // 262144 Hz
  localparam int DEF_TAP2    = 5;   // 65536 Hz
  localparam int DEF_TAP3    = 7;   // 16384 Hz
  localparam int DEF_APU_TAP = 12;  // 512 Hz frame sequencer

endpackage
`default_nettype wire

// File: rtl/gb_timer_ng_fall_edge.sv
`default_nettype none
// ============================================================================
// Module      : gb_fall_edge
// Description : Registered falling-edge detector with a clock enable. The
//               level register tracks d on every ce cycle; fall is high in a
//               ce cycle where the stored level is 1 and the incoming d is 0.
// Ports       : clk, reset (sync, active-high), ce (clock enable),
//               d (next level), fall (combinational falling-edge strobe)
// Revision    : 1.0 - initial release
// ============================================================================
module gb_fall_edge (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic d,
  output logic fall
);

  logic level_q;
  logic level_d;

  always_comb begin
    level_d = ce ? d : level_q;
    fall    = ce & level_q & ~d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gb_timer_ng.sv
`default_nettype none
// ============================================================================
// Module      : gb_timer_ng
// Description : Cycle-accurate DMG/CGB style timer/divider. DIV and the TIMA
//               increment come from one free-running system counter; TIMA
//               ticks on a falling edge of the TAC-selected tap, so DIV
//               resets and TAC changes can produce glitch increments. Models
//               the delayed overflow -> reload -> irq sequence and provides
//               the APU frame-sequencer tick.
// Ports       : clk, reset (sync, active-high), ce (4 MHz enable),
//               irq (timer interrupt pulse), apu_tick (frame-seq pulse),
//               cpu_sel/cpu_addr/cpu_wr/cpu_di (register write bus),
//               cpu_do (combinational read data)
// Revision    : 1.0 - initial release
// ============================================================================
module gb_timer_ng
  import gb_timer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TAP0    = DEF_TAP0,
  parameter int TAP1    = DEF_TAP1,
  parameter int TAP2    = DEF_TAP2,
  parameter int TAP3    = DEF_TAP3,
  parameter int APU_TAP = DEF_APU_TAP,
  parameter int OVF_DLY = 4,
  parameter int RLD_DLY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic       irq,
  output logic       apu_tick,
  input  logic       cpu_sel,
  input  logic [1:0] cpu_addr,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do
);

  localparam int DLY_MAX = (OVF_DLY > RLD_DLY) ? OVF_DLY : RLD_DLY;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic [7:0]       tima_q, tima_d;
  logic [7:0]       tma_q, tma_d;
  logic [2:0]       tac_q, tac_d, tac_nx;
  state_t           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             irq_q, irq_d;
  logic             apu_tick_q, apu_tick_d;

  logic wr_div, wr_tima, wr_tma, wr_tac;
  logic tap_bit, mux_nx, tick, apu_fall;

  // Write strobes only count in ce cycles
  always_comb begin
    wr_div  = ce & cpu_sel & cpu_wr & (cpu_addr == A_DIV);
    wr_tima = ce & cpu_sel & cpu_wr & (cpu_addr == A_TIMA);
    wr_tma  = ce & cpu_sel & cpu_wr & (cpu_addr == A_TMA);
    wr_tac  = ce & cpu_sel & cpu_wr & (cpu_addr == A_TAC);
  end

  // Next counter / TAC values; the tap mux looks at these so that a DIV
  // reset or TAC change in this cycle can create a falling edge.
  always_comb begin
    cnt_nx = wr_div ? '0 : cnt_q + CNT_W'(1);
    tac_nx = wr_tac ? cpu_di[2:0] : tac_q;
    case (tac_nx[1:0])
      2'b00:   tap_bit = cnt_nx[TAP0];
      2'b01:   tap_bit = cnt_nx[TAP1];
      2'b10:   tap_bit = cnt_nx[TAP2];
      default: tap_bit = cnt_nx[TAP3];
    endcase
    mux_nx = tac_nx[2] & tap_bit;
  end

  gb_fall_edge u_tima_edge (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .d     (mux_nx),
    .fall  (tick)
  );

  gb_fall_edge u_apu_edge (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .d     (cnt_nx[APU_TAP]),
    .fall  (apu_fall)
  );

  always_comb begin
    cnt_d      = ce ? cnt_nx : cnt_q;
    tac_d      = tac_nx;
    tima_d     = tima_q;
    tma_d      = tma_q;
    state_d    = state_q;
    dly_d      = dly_q;
    irq_d      = 1'b0;
    apu_tick_d = apu_fall;

    if (ce) begin
      if (wr_tma) tma_d = cpu_di;

      case (state_q)
        RUN: begin
          if (wr_tima) begin
            tima_d = cpu_di;
          end else if (tick) begin
            if (tima_q == 8'hFF) begin
              tima_d  = 8'h00;
              state_d = OVF;
              dly_d   = DLY_W'(OVF_DLY - 1);
            end else begin
              tima_d = tima_q + 8'd1;
            end
          end
        end
        OVF: begin
          if (wr_tima) begin
            // CPU write aborts the pending reload and interrupt
            tima_d  = cpu_di;
            state_d = RUN;
          end else if (dly_q == '0) begin
            // tma_d so that a TMA write in this same cycle is what reloads
            tima_d  = tma_d;
            irq_d   = 1'b1;
            state_d = RLD;
            dly_d   = DLY_W'(RLD_DLY - 1);
          end else begin
            dly_d = dly_q - DLY_W'(1);
            if (tick) tima_d = tima_q + 8'd1;
          end
        end
        RLD: begin
          // TIMA writes and ticks are dropped; TMA writes pass through
          if (wr_tma) tima_d = cpu_di;
          if (dly_q == '0) begin
            state_d = RUN;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      tima_q     <= 8'h00;
      tma_q      <= 8'h00;
      tac_q      <= 3'b000;
      state_q    <= RUN;
      dly_q      <= '0;
      irq_q      <= 1'b0;
      apu_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tima_q     <= tima_d;
      tma_q      <= tma_d;
      tac_q      <= tac_d;
      state_q    <= state_d;
      dly_q      <= dly_d;
      irq_q      <= irq_d;
      apu_tick_q <= apu_tick_d;
    end
  end

  always_comb begin
    case (cpu_addr)
      A_DIV:   cpu_do = cnt_q[CNT_W-1 -: 8];
      A_TIMA:  cpu_do = tima_q;
      A_TMA:   cpu_do = tma_q;
      default: cpu_do = {5'b11111, tac_q};
    endcase
  end

  assign irq      = irq_q;
  assign apu_tick = apu_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_gb_timer_ng.sv
`default_nettype none
// ============================================================================
// Module      : tb_gb_timer_ng
// Description : Self-checking bench for gb_timer_ng. A behavioural model
//               (integer counter, phase + remaining-cycle counters) runs in
//               lockstep; a vector table covers register read-back, hand
//               sequences cover overflow/reload/glitch corners, and a
//               randomized phase exercises everything against the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_timer_ng;
  import gb_timer_pkg::*;

  localparam int OVF_N = 4;
  localparam int RLD_N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       irq, apu_tick;
  logic       cpu_sel = 1'b0;
  logic [1:0] cpu_addr = 2'd0;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_di = 8'h00;
  logic [7:0] cpu_do;

  gb_timer_ng dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .irq      (irq),
    .apu_tick (apu_tick),
    .cpu_sel  (cpu_sel),
    .cpu_addr (cpu_addr),
    .cpu_wr   (cpu_wr),
    .cpu_di   (cpu_di),
    .cpu_do   (cpu_do)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  int       m_cnt;      // system counter as a plain integer
  bit [7:0] m_tima, m_tma;
  bit [2:0] m_tac;
  int       m_phase;    // 0 counting, 1 overflow pending, 2 reload window
  int       m_left;     // ce cycles remaining in the current phase
  bit       m_irq, m_apu;

  function automatic int tap_of(bit [1:0] s);
    case (s)
      2'd0:    return 9;
      2'd1:    return 3;
      2'd2:    return 5;
      default: return 7;
    endcase
  endfunction

  function automatic bit sel_level(int cnt, bit [2:0] tac);
    return tac[2] && (((cnt >> tap_of(tac[1:0])) & 1) == 1);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0;
    m_phase = 0; m_left = 0; m_irq = 0; m_apu = 0;
  endtask

  task automatic model_step(input bit c, input bit w, input bit [1:0] a, input bit [7:0] d);
    int new_cnt;
    bit [2:0] new_tac;
    bit tick;
    m_irq = 0;
    m_apu = 0;
    if (!c) return;
    new_cnt = (w && a == A_DIV) ? 0 : (m_cnt + 1) % 65536;
    new_tac = (w && a == A_TAC) ? d[2:0] : m_tac;
    tick    = sel_level(m_cnt, m_tac) && !sel_level(new_cnt, new_tac);
    m_apu   = (((m_cnt >> 12) & 1) == 1) && (((new_cnt >> 12) & 1) == 0);
    if (w && a == A_TMA) m_tma = d;
    case (m_phase)
      0: begin
        if (w && a == A_TIMA) m_tima = d;
        else if (tick) begin
          if (m_tima == 8'hFF) begin
            m_tima = 0; m_phase = 1; m_left = OVF_N;
          end else m_tima = m_tima + 1;
        end
      end
      1: begin
        if (w && a == A_TIMA) begin
          m_tima = d; m_phase = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_tima = m_tma; m_irq = 1; m_phase = 2; m_left = RLD_N;
          end else if (tick) m_tima = m_tima + 1;
        end
      end
      default: begin
        if (w && a == A_TMA) m_tima = d;
        m_left--;
        if (m_left == 0) m_phase = 0;
      end
    endcase
    m_cnt = new_cnt;
    m_tac = new_tac;
  endtask

  function automatic int model_read(int a);
    case (a)
      0:       return (m_cnt >> 8) & 255;
      1:       return int'(m_tima);
      2:       return int'(m_tma);
      default: return 248 | int'(m_tac);
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    cpu_addr = a;
    #1;
    v = cpu_do;
  endtask

  task automatic check_all();
    logic [7:0] v;
    chk("model_irq", int'(irq), int'(m_irq));
    chk("model_apu_tick", int'(apu_tick), int'(m_apu));
    rd(A_DIV, v);  chk("model_div", int'(v), model_read(0));
    rd(A_TIMA, v); chk("model_tima", int'(v), model_read(1));
    rd(A_TMA, v);  chk("model_tma", int'(v), model_read(2));
    rd(A_TAC, v);  chk("model_tac", int'(v), model_read(3));
  endtask

  task automatic step(input bit c, input bit s, input bit w, input bit [1:0] a, input bit [7:0] d);
    ce = c; cpu_sel = s; cpu_wr = w; cpu_addr = a; cpu_di = d;
    @(posedge clk);
    model_step(c, s && w, a, d);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic wr(input bit [1:0] a, input bit [7:0] d);
    step(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b1; cpu_wr = 1'b0; cpu_sel = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all();
  endtask

  // Leaves cnt=0, TAC=05 (tap bit 3), given TIMA/TMA
  task automatic setup(input bit [7:0] tima_v, input bit [7:0] tma_v);
    do_reset();
    wr(A_TMA, tma_v);
    wr(A_TIMA, tima_v);
    wr(A_TAC, 8'h05);
    wr(A_DIV, 8'h00);
  endtask

  typedef struct {
    logic [1:0] addr;
    logic [7:0] di;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[7];
    logic [7:0] v;

    tbl[0] = '{A_TMA,  8'h5A, 8'h5A};
    tbl[1] = '{A_TAC,  8'hFA, 8'hFA};
    tbl[2] = '{A_TAC,  8'h00, 8'hF8};
    tbl[3] = '{A_TIMA, 8'h3C, 8'h3C};
    tbl[4] = '{A_TMA,  8'h00, 8'h00};
    tbl[5] = '{A_DIV,  8'h77, 8'h00};
    tbl[6] = '{A_TAC,  8'h07, 8'hFF};

    // Reset state
    do_reset();
    chk("reset_irq", int'(irq), 0);
    chk("reset_apu", int'(apu_tick), 0);
    rd(A_TIMA, v); chk("reset_tima", int'(v), 0);
    rd(A_TAC, v);  chk("reset_tac", int'(v), 8'hF8);

    // Register write/read-back table
    for (int i = 0; i < 7; i++) begin
      wr(tbl[i].addr, tbl[i].di);
      rd(tbl[i].addr, v);
      chk($sformatf("tbl%0d", i), int'(v), int'(tbl[i].exp));
    end

    // Basic counting and overflow -> reload -> irq
    setup(8'hFE, 8'h40);
    idle(15); rd(A_TIMA, v); chk("basic_fe_15", int'(v), 8'hFE);
    idle(1);  rd(A_TIMA, v); chk("basic_ff_16", int'(v), 8'hFF);
    idle(16); rd(A_TIMA, v); chk("basic_00_32", int'(v), 8'h00);
    idle(3);  rd(A_TIMA, v); chk("basic_00_35", int'(v), 8'h00);
    chk("basic_noirq_35", int'(irq), 0);
    idle(1);  rd(A_TIMA, v); chk("basic_reload_36", int'(v), 8'h40);
    chk("basic_irq_36", int'(irq), 1);
    idle(1);  chk("basic_irq_end_37", int'(irq), 0);

    // Cancelled reload
    setup(8'hFF, 8'h40);
    idle(16);
    wr(A_TIMA, 8'h12);
    rd(A_TIMA, v); chk("cancel_tima", int'(v), 8'h12);
    for (int i = 0; i < 6; i++) begin
      idle(1); chk("cancel_noirq", int'(irq), 0);
    end
    idle(8);  rd(A_TIMA, v); chk("cancel_hold_31", int'(v), 8'h12);
    idle(1);  rd(A_TIMA, v); chk("cancel_resume_32", int'(v), 8'h13);

    // Writes during the reload window
    setup(8'hFF, 8'h40);
    idle(20); chk("rld_irq", int'(irq), 1);
    wr(A_TIMA, 8'h99); rd(A_TIMA, v); chk("rld_tima_ignored", int'(v), 8'h40);
    wr(A_TMA, 8'h77);
    rd(A_TIMA, v); chk("rld_tma_tima", int'(v), 8'h77);
    rd(A_TMA, v);  chk("rld_tma", int'(v), 8'h77);

    // DIV glitch
    setup(8'h10, 8'h00);
    idle(8);
    wr(A_DIV, 8'h00);
    rd(A_TIMA, v); chk("divglitch_tima", int'(v), 8'h11);
    rd(A_DIV, v);  chk("divglitch_div", int'(v), 8'h00);

    // TAC glitches
    setup(8'h20, 8'h00);
    idle(8);
    wr(A_TAC, 8'h04); rd(A_TIMA, v); chk("tacglitch_tap", int'(v), 8'h21);
    wr(A_TAC, 8'h05); rd(A_TIMA, v); chk("tacglitch_rise", int'(v), 8'h21);
    wr(A_TAC, 8'h01); rd(A_TIMA, v); chk("tacglitch_disable", int'(v), 8'h22);

    // Reset in the middle of the overflow delay
    setup(8'hFF, 8'h40);
    idle(17);
    do_reset();
    rd(A_TIMA, v); chk("midovf_reset_tima", int'(v), 8'h00);
    chk("midovf_reset_irq", int'(irq), 0);
    idle(10);

    // APU tick, DIV rate and ce gating
    do_reset();
    idle(8191); chk("apu_before", int'(apu_tick), 0);
    idle(1);    chk("apu_first", int'(apu_tick), 1);
    idle(1);    chk("apu_pulse_end", int'(apu_tick), 0);
    idle(12300 - 8193);
    rd(A_DIV, v); chk("div_rate", int'(v), 8'h30);
    wr(A_DIV, 8'h00);
    chk("apu_div_write", int'(apu_tick), 1);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1, A_TIMA, 8'hAA);
    rd(A_TIMA, v); chk("gate_tima", int'(v), 8'h00);
    rd(A_DIV, v);  chk("gate_div", int'(v), 8'h00);
    idle(255); rd(A_DIV, v); chk("gate_div_255", int'(v), 8'h00);
    idle(1);   rd(A_DIV, v); chk("gate_div_256", int'(v), 8'h01);

    // Randomized phase against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit c, s, w;
      bit [1:0] a;
      bit [7:0] d;
      c = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 7) != 0);
      w = ($urandom_range(0, 7) == 0);
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (a == A_DIV && $urandom_range(0, 7) != 0) w = 1'b0;
      if (a == A_TIMA) d = 8'hF8 | d[2:0];
      if (a == A_TAC && d[0] == 1'b0) d = 8'h05;
      step(c, s, w, a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
